// File: rtl/bus_arbiter.sv
// bus_arbiter: registered round-robin arbiter that multiplexes several drivers onto one shared bus.
// Define BUS_ARB_LOCK_EN to enable owner lock/hold with a HOLD_MAX timeout; otherwise every grant lasts one cycle.
module bus_arbiter #(
  parameter int NREQ     = 4,
  parameter int DW       = 8,
  parameter int HOLD_MAX = 7
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [NREQ-1:0]         i_req,
  input  logic [NREQ-1:0]         i_lock,
  input  logic [NREQ*DW-1:0]      i_data_in,
  output logic [NREQ-1:0]         o_gnt,
  output logic [$clog2(NREQ)-1:0] o_owner,
  output logic                    o_bus_valid,
  output logic [DW-1:0]           o_bus_out,
  output logic                    o_hold_timeout
);
  localparam int PW = $clog2(NREQ);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t          r_state, w_nextState;
  logic [NREQ-1:0] r_gnt, w_nextGnt;
  logic [PW-1:0]   r_owner, w_nextOwner;
  logic [PW-1:0]   r_ptr, w_nextPtr;
  logic [PW-1:0]   w_k;
  logic [PW:0]     w_sum;
  logic [NREQ-1:0] w_rot;
  logic            w_found;
  logic            w_keep;
  logic            w_timeout;
  logic [DW-1:0]   w_bus;

`ifdef BUS_ARB_LOCK_EN
  localparam int HW = $clog2(HOLD_MAX + 1);

  logic [HW-1:0] r_hcnt, w_nextHcnt;
  logic          r_timeout;
  logic          w_locked;

  assign w_locked  = (r_state == OWNED) && i_req[r_owner] && i_lock[r_owner];
  assign w_keep    = w_locked && (r_hcnt < HW'(HOLD_MAX));
  assign w_timeout = w_locked && (r_hcnt == HW'(HOLD_MAX));

  always_comb begin
    w_nextHcnt = '0;
    if (w_keep) w_nextHcnt = r_hcnt + HW'(1);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_hcnt    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_hcnt    <= w_nextHcnt;
      r_timeout <= w_timeout;
    end
  end

  assign o_hold_timeout = r_timeout;
`else
  logic w_unused;

  assign w_unused       = &{1'b0, i_lock};
  assign w_keep         = 1'b0;
  assign w_timeout      = 1'b0;
  assign o_hold_timeout = 1'b0;
`endif

  // Rotate requests so bit 0 is the requester at ptr; the lowest set bit wins.
  always_comb begin
    w_rot   = NREQ'({i_req, i_req} >> r_ptr);
    w_found = 1'b0;
    w_sum   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_found = 1'b1;
        w_sum   = {1'b0, r_ptr} + (PW+1)'(i);
      end
    end
    if (w_sum >= (PW+1)'(NREQ)) w_sum = w_sum - (PW+1)'(NREQ);
    w_k = w_sum[PW-1:0];
  end

  always_comb begin
    w_nextState = r_state;
    w_nextGnt   = r_gnt;
    w_nextOwner = r_owner;
    w_nextPtr   = r_ptr;
    if (!w_keep) begin
      if (w_found) begin
        w_nextState = OWNED;
        w_nextGnt   = NREQ'(1) << w_k;
        w_nextOwner = w_k;
        w_nextPtr   = (w_k == PW'(NREQ - 1)) ? '0 : w_k + PW'(1);
      end else begin
        w_nextState = IDLE;
        w_nextGnt   = '0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_owner <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_nextState;
      r_gnt   <= w_nextGnt;
      r_owner <= w_nextOwner;
      r_ptr   <= w_nextPtr;
    end
  end

  always_comb begin
    w_bus = '0;
    for (int i = 0; i < NREQ; i++) begin
      if ((r_state == OWNED) && (r_owner == PW'(i))) w_bus = i_data_in[i*DW +: DW];
    end
  end

  assign o_gnt       = r_gnt;
  assign o_owner     = r_owner;
  assign o_bus_valid = (r_state == OWNED);
  assign o_bus_out   = w_bus;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed scenarios plus randomized traffic against a behavioural arbiter model.
// Follows BUS_ARB_LOCK_EN the same way the design does.
module tb_bus_arbiter;
  localparam int NREQ     = 4;
  localparam int DW       = 8;
  localparam int HOLD_MAX = 7;
`ifdef BUS_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rstN;
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    lock;
  logic [NREQ*DW-1:0] dataIn;
  logic [NREQ-1:0]    gnt;
  logic [1:0]         owner;
  logic               busValid;
  logic [DW-1:0]      busOut;
  logic               holdTimeout;

  int errors = 0;
  int checks = 0;

  // Reference model: who owns the bus, where the scan starts, how long the owner has held.
  bit mValid;
  int mOwner;
  int mPtr;
  int mHold;
  bit mTimeout;

  bus_arbiter #(.NREQ(NREQ), .DW(DW), .HOLD_MAX(HOLD_MAX)) dut (
    .i_clk(clk), .i_rst_n(rstN), .i_req(req), .i_lock(lock), .i_data_in(dataIn),
    .o_gnt(gnt), .o_owner(owner), .o_bus_valid(busValid), .o_bus_out(busOut),
    .o_hold_timeout(holdTimeout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic modelStep();
    bit held;
    if (!rstN) begin
      mValid = 0; mOwner = 0; mPtr = 0; mHold = 0; mTimeout = 0;
    end else begin
      held = LOCK_EN && mValid && req[mOwner] && lock[mOwner];
      if (held && mHold < HOLD_MAX) begin
        mHold++;
        mTimeout = 0;
      end else begin
        mTimeout = held;
        mHold    = 0;
        mValid   = 0;
        for (int j = 0; j < NREQ; j++) begin
          int idx;
          idx = (mPtr + j) % NREQ;
          if (!mValid && req[idx]) begin
            mValid = 1;
            mOwner = idx;
          end
        end
        if (mValid) mPtr = (mOwner + 1) % NREQ;
      end
    end
  endtask

  task automatic applyStimulus(input logic rstn, input logic [NREQ-1:0] r, input logic [NREQ-1:0] l,
                               input logic [NREQ*DW-1:0] d, input string tag);
    logic [DW-1:0] expBus;
    @(negedge clk);
    rstN = rstn; req = r; lock = l; dataIn = d;
    @(posedge clk);
    modelStep();
    #1;
    expBus = mValid ? d[mOwner*DW +: DW] : '0;
    checkOutput({tag, ".gnt"}, 32'(gnt), mValid ? (32'd1 << mOwner) : 32'd0);
    checkOutput({tag, ".owner"}, 32'(owner), 32'(mOwner));
    checkOutput({tag, ".valid"}, 32'(busValid), 32'(mValid));
    checkOutput({tag, ".bus"}, 32'(busOut), 32'(expBus));
    checkOutput({tag, ".timeout"}, 32'(holdTimeout), 32'(mTimeout));
  endtask

  initial begin
    logic [NREQ-1:0]    rrGnt [5];
    logic [DW-1:0]      rrBus [5];
    logic [NREQ*DW-1:0] pattern;

    rrGnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rrBus = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    pattern = 32'h44332211;
    rstN = 1'b0; req = '0; lock = '0; dataIn = '0;

    // Reset with everyone requesting, then round robin from requester 0
    applyStimulus(1'b0, 4'b1111, 4'b0000, pattern, "reset0");
    applyStimulus(1'b0, 4'b1111, 4'b0000, pattern, "reset1");
    checkOutput("reset.gnt", 32'(gnt), 32'd0);
    checkOutput("reset.bus", 32'(busOut), 32'd0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 4'b1111, 4'b0000, pattern, "rr");
      checkOutput("rr.gntConst", 32'(gnt), 32'(rrGnt[i]));
      checkOutput("rr.busConst", 32'(busOut), 32'(rrBus[i]));
    end

    // Single one-cycle request
    applyStimulus(1'b1, 4'b0100, 4'b0000, 32'h00A50000, "pulse");
    checkOutput("pulse.gntConst", 32'(gnt), 32'b0100);
    checkOutput("pulse.busConst", 32'(busOut), 32'hA5);
    applyStimulus(1'b1, 4'b0000, 4'b0000, 32'h00A50000, "pulseEnd");
    checkOutput("pulseEnd.gntConst", 32'(gnt), 32'd0);
    checkOutput("pulseEnd.busConst", 32'(busOut), 32'd0);

`ifdef BUS_ARB_LOCK_EN
    // Lock timeout: eight cycles for requester 0, forced handover, then back
    applyStimulus(1'b0, 4'b0000, 4'b0000, pattern, "rstLock");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 4'b0011, 4'b0001, pattern, "lock");
      checkOutput("lock.gntConst", 32'(gnt), (i == 8) ? 32'b0010 : 32'b0001);
      checkOutput("lock.toConst", 32'(holdTimeout), (i == 8) ? 32'd1 : 32'd0);
    end

    // Reset in the middle of a hold
    applyStimulus(1'b0, 4'b0000, 4'b0000, pattern, "rstHold");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 4'b0001, 4'b0001, pattern, "hold");
    applyStimulus(1'b0, 4'b0001, 4'b0001, pattern, "midReset");
    checkOutput("midReset.gntConst", 32'(gnt), 32'd0);
    checkOutput("midReset.toConst", 32'(holdTimeout), 32'd0);
    applyStimulus(1'b1, 4'b1010, 4'b0000, pattern, "afterReset");
    checkOutput("afterReset.gntConst", 32'(gnt), 32'b0010);
`else
    // Without lock support, a locked owner still yields every cycle
    applyStimulus(1'b0, 4'b0000, 4'b0000, pattern, "rstNoLock");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 4'b0011, 4'b0001, pattern, "noLock");
      checkOutput("noLock.gntConst", 32'(gnt), (i % 2 == 0) ? 32'b0001 : 32'b0010);
      checkOutput("noLock.toConst", 32'(holdTimeout), 32'd0);
    end
`endif

    // Randomized traffic with heavy locking and occasional resets
    for (int i = 0; i < 600; i++) begin
      logic          rr;
      logic [NREQ-1:0] rq;
      logic [NREQ-1:0] lk;
      rr = ($urandom_range(0, 39) != 0);
      rq = ($urandom_range(0, 3) == 0) ? NREQ'($urandom) : (req | NREQ'($urandom_range(0, 1)));
      lk = NREQ'($urandom) | NREQ'($urandom);
      applyStimulus(rr, rq, lk, $urandom, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
